// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mips_ctrl_pkg
//  Brief   : Shared encodings for the multicycle MIPS main control unit:
//            opcodes, ALUOp codes, FSM states, datapath select codes and
//            the I-type ALU decode helper.
//  Rev     : 1.0  initial release
// ============================================================================
package mips_ctrl_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALUOp encodings understood by the ALU control decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_XOR   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_FUNCT = 3'b110;
  localparam logic [2:0] ALUOP_SLTU  = 3'b111;

  // FSM state encodings
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] EXEC_R   = 4'd3;
  localparam logic [3:0] EXEC_I   = 4'd4;
  localparam logic [3:0] ALU_WB   = 4'd5;
  localparam logic [3:0] MEM_ADDR = 4'd6;
  localparam logic [3:0] MEM_RD   = 4'd7;
  localparam logic [3:0] MEM_WB   = 4'd8;
  localparam logic [3:0] MEM_WR   = 4'd9;
  localparam logic [3:0] BRANCH   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;
  localparam logic [3:0] HALT     = 4'd12;

  // Register-file destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;
  localparam logic [1:0] MTR_LUI    = 2'b11;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REGA = 2'b01;

  // ALU operand B select; code 11 means zero-ext imm in EXEC_I and
  // sign-ext imm<<2 in DECODE, the datapath picks by state
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SIMM = 2'b10;
  localparam logic [1:0] SRCB_EXT  = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src_b;
  } exec_i_ctrl_t;

  // Immediate-type ALU control: logical ops zero-extend, arithmetic and
  // compare ops sign-extend; lui bypasses the ALU entirely.
  function automatic exec_i_ctrl_t exec_i_decode(input logic [5:0] op);
    exec_i_ctrl_t c;
    c.alu_op    = ALUOP_ADD;
    c.alu_src_b = SRCB_REGB;
    case (op)
      OP_ADDI:  begin c.alu_op = ALUOP_ADD;  c.alu_src_b = SRCB_SIMM; end
      OP_ANDI:  begin c.alu_op = ALUOP_AND;  c.alu_src_b = SRCB_EXT;  end
      OP_ORI:   begin c.alu_op = ALUOP_OR;   c.alu_src_b = SRCB_EXT;  end
      OP_XORI:  begin c.alu_op = ALUOP_XOR;  c.alu_src_b = SRCB_EXT;  end
      OP_SLTI:  begin c.alu_op = ALUOP_SLT;  c.alu_src_b = SRCB_SIMM; end
      OP_SLTIU: begin c.alu_op = ALUOP_SLTU; c.alu_src_b = SRCB_SIMM; end
      default:  begin c.alu_op = ALUOP_ADD;  c.alu_src_b = SRCB_REGB; end
    endcase
    return c;
  endfunction

  // Opcodes routed to EXEC_I
  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_SLTI) || (op == OP_SLTIU) ||
           (op == OP_LUI);
  endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : mc_ctrl_fsm
//  Brief   : Multicycle MIPS main control FSM. Sequences fetch, decode,
//            execute, memory and writeback over a shared ALU/memory port.
//            Outputs are decoded from state, with mem_ready, zero and jr
//            folded into the handful of strobes that depend on them.
//  Rev     : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                jr,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                invalid_op
);

  logic [3:0]   r_state;
  logic [3:0]   w_next;
  logic         r_invalid_op;
  exec_i_ctrl_t w_ictl;

  assign w_ictl     = exec_i_decode(opcode);
  assign invalid_op = r_invalid_op;

  // State register and sticky invalid-opcode flag; reset overrides any wait
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RST;
      r_invalid_op <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == HALT) begin
        r_invalid_op <= 1'b1;
      end
    end
  end

  // Next-state decode, including opcode dispatch out of DECODE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:  w_next = FETCH;
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == OP_RTYPE) begin
          w_next = EXEC_R;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          w_next = MEM_ADDR;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          w_next = BRANCH;
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
          w_next = JUMP;
        end else if (is_itype(opcode)) begin
          w_next = EXEC_I;
        end else begin
          w_next = HALT;
        end
      end
      EXEC_R:   w_next = jr ? FETCH : ALU_WB;
      EXEC_I:   w_next = ALU_WB;
      ALU_WB:   w_next = FETCH;
      MEM_ADDR: w_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   w_next = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   w_next = FETCH;
      MEM_WR:   w_next = mem_ready ? FETCH : MEM_WR;
      BRANCH:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      HALT:     w_next = HALT;
      default:  w_next = S_RST;
    endcase
  end

  // Datapath control decode; every state starts from all-zero controls
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = MTR_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALUOP_ADD;
    pc_source  = PCSRC_ALU;
    case (r_state)
      FETCH: begin
        // PC+4 computed on the ALU while the instruction is read
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        // Speculatively form the branch target into ALUOut
        alu_src_b = SRCB_EXT;
      end
      EXEC_R: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALUOP_FUNCT;
        if (jr) begin
          pc_write  = 1'b1;
          pc_source = PCSRC_REGA;
        end
      end
      EXEC_I: begin
        alu_src_a = SRCA_REGA;
        alu_op    = w_ictl.alu_op;
        alu_src_b = w_ictl.alu_src_b;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        if (opcode == OP_RTYPE) begin
          reg_dst = REGDST_RD;
        end else if (opcode == OP_LUI) begin
          mem_to_reg = MTR_LUI;
        end
      end
      MEM_ADDR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_SIMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = MTR_MDR;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      BRANCH: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        if (opcode == OP_JAL) begin
          // Link register receives the already-incremented PC
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = MTR_PC;
        end
      end
      default: begin
        // S_RST and HALT keep every control at zero
      end
    endcase
  end

endmodule : mc_ctrl_fsm
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mc_ctrl_fsm
//  Brief   : Self-checking bench for mc_ctrl_fsm. Instructions are expanded
//            into per-cycle {inputs, expected outputs} records by an
//            instruction-level model, then replayed against the DUT.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       invalid_op;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       jr;
    logic       zero;
    logic       mr;
    logic       chk;
    outs_t      exp;
    string      tag;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       jr = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       invalid_op;

  int checks = 0;
  int failures = 0;

  vec_t q[$];
  logic model_inv = 1'b0;

  logic [5:0] valid_ops [14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b000010, 6'b000011, 6'b001000,
                                 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                                 6'b001011, 6'b001111};

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .jr(jr), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .invalid_op(invalid_op)
  );

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  // Idle control word; only the sticky flag carries over
  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.invalid_op = model_inv;
    return o;
  endfunction

  task automatic check_outs(input outs_t exp, input string tag, input int idx);
    outs_t act;
    act = {pc_write, ir_write, mem_read, mem_write, iord, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, invalid_op};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d op=%b actual=%b required=%b",
               tag, idx, opcode, act, exp);
    end
  endtask

  task automatic push(input logic rst, input logic [5:0] op, input logic j,
                      input logic z, input logic mr, input logic chk,
                      input outs_t e, input string tag);
    vec_t v;
    v.rst = rst; v.op = op; v.jr = j; v.zero = z; v.mr = mr;
    v.chk = chk; v.exp = e; v.tag = tag;
    q.push_back(v);
  endtask

  // Reset pulse from a state whose outputs are already known (cur), then
  // the S_RST cycle with everything low
  task automatic gen_reset(input logic chk, input outs_t cur, input logic [5:0] op,
                           input logic mr);
    push(1'b1, op, rb(), rb(), mr, chk, cur, "reset_cycle");
    model_inv = 1'b0;
    push(1'b0, op, rb(), rb(), rb(), 1'b1, '0, "s_rst");
  endtask

  task automatic gen_fetch_decode(input logic [5:0] op, input int wf);
    outs_t e;
    for (int i = 0; i <= wf; i++) begin
      e = base();
      e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      e.ir_write = (i == wf); e.pc_write = (i == wf);
      push(1'b0, op, rb(), rb(), (i == wf), 1'b1, e, "fetch");
    end
    e = base();
    e.alu_src_b = 2'b11;
    push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "decode");
  endtask

  // One complete instruction; j and z are the jr/zero values seen in the
  // cycle where they matter, wf/wm the fetch and data-memory wait counts
  task automatic gen_instr(input logic [5:0] op, input int wf, input int wm,
                           input logic j, input logic z);
    outs_t e;
    gen_fetch_decode(op, wf);
    case (op)
      6'b000000: begin
        e = base();
        e.alu_src_a = 2'b01; e.alu_op = 3'b110;
        if (j) begin e.pc_write = 1'b1; e.pc_source = 2'b11; end
        push(1'b0, op, j, rb(), rb(), 1'b1, e, "exec_r");
        if (!j) begin
          e = base();
          e.reg_write = 1'b1; e.reg_dst = 2'b01;
          push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "alu_wb_r");
        end
      end
      6'b100011, 6'b101011: begin
        e = base();
        e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
        push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "mem_addr");
        for (int i = 0; i <= wm; i++) begin
          e = base();
          e.iord = 1'b1;
          if (op == 6'b100011) e.mem_read = 1'b1; else e.mem_write = 1'b1;
          push(1'b0, op, rb(), rb(), (i == wm), 1'b1, e, "mem_access");
        end
        if (op == 6'b100011) begin
          e = base();
          e.reg_write = 1'b1; e.mem_to_reg = 2'b01;
          push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "mem_wb");
        end
      end
      6'b000100, 6'b000101: begin
        e = base();
        e.alu_src_a = 2'b01; e.alu_op = 3'b001; e.pc_source = 2'b01;
        e.pc_write = (op == 6'b000100) ? z : ~z;
        push(1'b0, op, rb(), z, rb(), 1'b1, e, "branch");
      end
      6'b000010, 6'b000011: begin
        e = base();
        e.pc_write = 1'b1; e.pc_source = 2'b10;
        if (op == 6'b000011) begin
          e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
        end
        push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "jump");
      end
      default: begin
        e = base();
        e.alu_src_a = 2'b01;
        case (op)
          6'b001000: begin e.alu_op = 3'b000; e.alu_src_b = 2'b10; end
          6'b001100: begin e.alu_op = 3'b010; e.alu_src_b = 2'b11; end
          6'b001101: begin e.alu_op = 3'b011; e.alu_src_b = 2'b11; end
          6'b001110: begin e.alu_op = 3'b100; e.alu_src_b = 2'b11; end
          6'b001010: begin e.alu_op = 3'b101; e.alu_src_b = 2'b10; end
          6'b001011: begin e.alu_op = 3'b111; e.alu_src_b = 2'b10; end
          default:   begin e.alu_op = 3'b000; e.alu_src_b = 2'b00; end
        endcase
        push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "exec_i");
        e = base();
        e.reg_write = 1'b1;
        if (op == 6'b001111) e.mem_to_reg = 2'b11;
        push(1'b0, op, rb(), rb(), rb(), 1'b1, e, "alu_wb_i");
      end
    endcase
  endtask

  task automatic gen_random(input int n);
    logic [5:0] op;
    for (int k = 0; k < n; k++) begin
      op = valid_ops[$urandom_range(0, 13)];
      gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
    end
  endtask

  initial begin
    outs_t e;
    logic [5:0] bad;

    // Power-up: the reset cycle itself starts from an unknown state
    push(1'b1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0, "init");
    gen_reset(1'b1, '0, 6'd0, 1'b1);

    // Directed instructions
    gen_instr(6'b000000, 0, 0, 1'b0, 1'b0);   // add
    gen_instr(6'b100011, 0, 3, 1'b0, 1'b0);   // lw, 3 wait cycles
    gen_instr(6'b000100, 0, 0, 1'b0, 1'b1);   // beq taken
    gen_instr(6'b000101, 0, 0, 1'b0, 1'b1);   // bne not taken
    gen_instr(6'b000000, 1, 0, 1'b1, 1'b0);   // jr
    gen_instr(6'b000011, 0, 0, 1'b0, 1'b0);   // jal
    gen_instr(6'b001111, 0, 0, 1'b0, 1'b0);   // lui
    gen_instr(6'b101011, 2, 1, 1'b0, 1'b0);   // sw

    gen_random(120);

    // sw interrupted by reset while waiting on memory
    gen_fetch_decode(6'b101011, 0);
    e = base(); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10;
    push(1'b0, 6'b101011, rb(), rb(), rb(), 1'b1, e, "mem_addr");
    e = base(); e.mem_write = 1'b1; e.iord = 1'b1;
    push(1'b0, 6'b101011, rb(), rb(), 1'b0, 1'b1, e, "mem_wr_wait");
    push(1'b0, 6'b101011, rb(), rb(), 1'b0, 1'b1, e, "mem_wr_wait");
    gen_reset(1'b1, e, 6'b101011, 1'b0);

    gen_random(40);

    // Unsupported opcode: absorbing halt, then reset clears the flag
    bad = 6'b111111;
    gen_fetch_decode(bad, 0);
    model_inv = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(1'b0, bad, rb(), rb(), rb(), 1'b1, base(), "halt");
    end
    gen_reset(1'b1, base(), bad, rb());
    gen_instr(6'b000000, 0, 0, 1'b0, 1'b0);

    // A second, random unsupported opcode
    do bad = 6'($urandom_range(0, 63));
    while (bad inside {valid_ops});
    gen_fetch_decode(bad, 1);
    model_inv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, bad, rb(), rb(), rb(), 1'b1, base(), "halt_rand");
    end
    gen_reset(1'b1, base(), bad, rb());

    // Replay
    @(posedge clk); #1;
    foreach (q[i]) begin
      reset = q[i].rst; opcode = q[i].op; jr = q[i].jr;
      zero = q[i].zero; mem_ready = q[i].mr;
      @(negedge clk);
      if (q[i].chk) begin
        check_outs(q[i].exp, q[i].tag, i);
      end
      @(posedge clk); #1;
    end

    // Directed reset-state check
    reset = 1'b1; opcode = 6'd0; jr = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outs('0, "reset_state", -1);
    @(posedge clk); #1;

    // Directed expired-wait check: FETCH held while mem_ready stays low
    model_inv = 1'b0;
    e = base(); e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs(e, "fetch_wait", -2);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    check_outs(e, "fetch_wait_done", -3);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    e = base(); e.alu_src_b = 2'b11;
    check_outs(e, "decode_after_wait", -4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mc_ctrl_fsm
`default_nettype wire
